// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - RV32M sequencer between the ex stage and the iterative mul/div unit
// Resolves divide special cases locally, runs the unit handshake with a busy watchdog.
module muldiv_ctrl #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] operand1_i,
   input  logic [31:0] operand2_i,
   input  logic        advance_i,
   input  logic        flush_i,
   input  logic        muldiv_done_i,
   input  logic [63:0] muldiv_result_i,
   output logic        muldiv_start_o,
   output logic        muldiv_abort_o,
   output logic [31:0] muldiv_dividend_o,
   output logic [31:0] muldiv_divisor_o,
   output logic        mul_or_div_o,
   output logic        muldiv_reg1_signed0_unsigned1,
   output logic        muldiv_reg2_signed0_unsigned1,
   output logic [31:0] result_o,
   output logic        result_valid_o,
   output logic        stall_req_o,
   output logic        timeout_err_o
);

   localparam logic OP_MUL   = 1'b0;
   localparam logic UNSIGNED = 1'b1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic [31:0]       r_op1;
   logic [31:0]       r_op2;
   logic              r_mod;
   logic              r_uns1;
   logic              r_uns2;
   logic [31:0]       r_result;
   logic              r_terr;

   logic              w_div_zero;
   logic              w_div_ovf;
   logic              w_special;
   logic [31:0]       w_fast_result;
   logic              w_uns1;
   logic              w_uns2;
   logic              w_cnt_max;
   logic              w_sel_lo;
   logic [31:0]       w_unit_word;
   logic              w_abort;
   logic              w_accept;
   logic              w_timeout;
   logic              w_res_ld;
   logic [31:0]       w_res_nxt;

   // op_i[2]: divide family, op_i[1]: remainder, op_i[0]: unsigned divide
   assign w_div_zero = (operand2_i == 32'h0000_0000);
   assign w_div_ovf  = ~op_i[0] & (operand1_i == 32'h8000_0000) & (operand2_i == 32'hFFFF_FFFF);
   assign w_special  = op_i[2] & (w_div_zero | w_div_ovf);

   always_comb begin
      w_fast_result = 32'h0000_0000;
      if (w_div_zero)
         w_fast_result = op_i[1] ? operand1_i : 32'hFFFF_FFFF;
      else
         w_fast_result = op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
   end

   assign w_uns1 = (op_i == 3'd0) | (op_i == 3'd3) | (op_i == 3'd5) | (op_i == 3'd7);
   assign w_uns2 = w_uns1 | (op_i == 3'd2);

   assign w_cnt_max   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
   assign w_sel_lo    = (r_op == 3'd0) | (r_op[2:1] == 2'b11);
   assign w_unit_word = w_sel_lo ? muldiv_result_i[31:0] : muldiv_result_i[63:32];

   always_comb begin
      w_next    = r_state;
      w_abort   = 1'b0;
      w_accept  = 1'b0;
      w_timeout = 1'b0;
      w_res_ld  = 1'b0;
      w_res_nxt = 32'h0000_0000;
      case (r_state)
         S_IDLE: begin
            if (req_i && !flush_i) begin
               if (w_special) begin
                  w_next    = S_DONE;
                  w_res_ld  = 1'b1;
                  w_res_nxt = w_fast_result;
               end else begin
                  w_next   = S_BUSY;
                  w_accept = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (flush_i) begin
               w_next  = S_IDLE;
               w_abort = 1'b1;
            end else if (muldiv_done_i) begin
               w_next    = S_DONE;
               w_res_ld  = 1'b1;
               w_res_nxt = w_unit_word;
            end else if (w_cnt_max) begin
               w_next    = S_DONE;
               w_abort   = 1'b1;
               w_timeout = 1'b1;
               w_res_ld  = 1'b1;
            end
         end
         S_DONE: begin
            if (flush_i || advance_i)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= 3'd0;
         r_op1    <= 32'h0000_0000;
         r_op2    <= 32'h0000_0000;
         r_mod    <= OP_MUL;
         r_uns1   <= UNSIGNED;
         r_uns2   <= UNSIGNED;
         r_result <= 32'h0000_0000;
         r_terr   <= 1'b0;
      end else begin
         r_state <= w_next;
         // counter is zero on the first BUSY cycle, so the watchdog fires on cycle TIMEOUT_CYCLES
         if (r_state == S_BUSY)
            r_cnt <= r_cnt + CNT_W'(1);
         else
            r_cnt <= '0;
         if (w_accept) begin
            r_op   <= op_i;
            r_op1  <= operand1_i;
            r_op2  <= operand2_i;
            r_mod  <= op_i[2];
            r_uns1 <= w_uns1;
            r_uns2 <= w_uns2;
         end
         if (flush_i)
            r_result <= 32'h0000_0000;
         else if (w_res_ld)
            r_result <= w_res_nxt;
         if (w_timeout)
            r_terr <= 1'b1;
      end
   end

   assign muldiv_start_o                = (r_state == S_BUSY);
   assign muldiv_abort_o                = w_abort;
   assign muldiv_dividend_o             = r_op1;
   assign muldiv_divisor_o              = r_op2;
   assign mul_or_div_o                  = r_mod;
   assign muldiv_reg1_signed0_unsigned1 = r_uns1;
   assign muldiv_reg2_signed0_unsigned1 = r_uns2;
   assign result_o                      = r_result;
   assign result_valid_o                = (r_state == S_DONE);
   assign stall_req_o                   = req_i & ~flush_i & (r_state != S_DONE);
   assign timeout_err_o                 = r_terr;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl (default and short-watchdog instances)
module tb_muldiv_ctrl;

   typedef struct {
      int          id;
      bit          is_abort;
      logic [31:0] res;
      int          scyc;
      bit          s1;
      bit          s2;
      bit          md;
      bit          terr;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req [2];
   logic [2:0]  op  [2];
   logic [31:0] a   [2];
   logic [31:0] b   [2];
   logic        adv [2];
   logic        fl  [2];
   logic        dn  [2];
   logic [63:0] ur  [2];
   logic        st  [2];
   logic        ab  [2];
   logic [31:0] dvd [2];
   logic [31:0] dvs [2];
   logic        mdo [2];
   logic        s1o [2];
   logic        s2o [2];
   logic [31:0] res [2];
   logic        vo  [2];
   logic        stl [2];
   logic        te  [2];

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   bit   rst_seen = 0;
   bit   end_req = 0;
   bit   mon_done = 0;
   bit   p_start [2];
   bit   p_valid [2];
   int   scnt [2];

   always #5 clk = ~clk;

   muldiv_ctrl u_dut (
      .clk(clk), .rst(rst), .req_i(req[0]), .op_i(op[0]),
      .operand1_i(a[0]), .operand2_i(b[0]), .advance_i(adv[0]), .flush_i(fl[0]),
      .muldiv_done_i(dn[0]), .muldiv_result_i(ur[0]),
      .muldiv_start_o(st[0]), .muldiv_abort_o(ab[0]),
      .muldiv_dividend_o(dvd[0]), .muldiv_divisor_o(dvs[0]), .mul_or_div_o(mdo[0]),
      .muldiv_reg1_signed0_unsigned1(s1o[0]), .muldiv_reg2_signed0_unsigned1(s2o[0]),
      .result_o(res[0]), .result_valid_o(vo[0]), .stall_req_o(stl[0]), .timeout_err_o(te[0])
   );

   muldiv_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) u_dut_to (
      .clk(clk), .rst(rst), .req_i(req[1]), .op_i(op[1]),
      .operand1_i(a[1]), .operand2_i(b[1]), .advance_i(adv[1]), .flush_i(fl[1]),
      .muldiv_done_i(dn[1]), .muldiv_result_i(ur[1]),
      .muldiv_start_o(st[1]), .muldiv_abort_o(ab[1]),
      .muldiv_dividend_o(dvd[1]), .muldiv_divisor_o(dvs[1]), .mul_or_div_o(mdo[1]),
      .muldiv_reg1_signed0_unsigned1(s1o[1]), .muldiv_reg2_signed0_unsigned1(s2o[1]),
      .result_o(res[1]), .result_valid_o(vo[1]), .stall_req_o(stl[1]), .timeout_err_o(te[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic unexp(input string name, input int id);
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_%s on dut%0d: got event expected none", name, id);
   endtask

   // monitor: pops the scoreboard on start rise (peek), abort pulses and valid rise
   always @(negedge clk) begin
      if (rst) begin
         if (!rst_seen) begin
            rst_seen = 1;
            chk("rst_start", {31'd0, st[0]}, 32'd0);
            chk("rst_abort", {31'd0, ab[0]}, 32'd0);
            chk("rst_valid", {31'd0, vo[0]}, 32'd0);
            chk("rst_result", res[0], 32'd0);
            chk("rst_sign1", {31'd0, s1o[0]}, 32'd1);
            chk("rst_sign2", {31'd0, s2o[0]}, 32'd1);
            chk("rst_mul_or_div", {31'd0, mdo[0]}, 32'd0);
            chk("rst_dividend", dvd[0], 32'd0);
            chk("rst_stall", {31'd0, stl[0]}, 32'd0);
            chk("rst_timeout_err", {31'd0, te[0]}, 32'd0);
            chk("rst_timeout_err_to", {31'd0, te[1]}, 32'd0);
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (st[i]) begin
               if (!p_start[i]) begin
                  scnt[i] = 1;
                  if (q.size() == 0 || q[0].id != i) unexp("start", i);
                  else begin
                     chk("start_sign1", {31'd0, s1o[i]}, {31'd0, q[0].s1});
                     chk("start_sign2", {31'd0, s2o[i]}, {31'd0, q[0].s2});
                     chk("start_mul_or_div", {31'd0, mdo[i]}, {31'd0, q[0].md});
                     chk("start_dividend", dvd[i], q[0].a);
                     chk("start_divisor", dvs[i], q[0].b);
                     chk("busy_stall", {31'd0, stl[i]}, 32'd1);
                  end
               end else begin
                  scnt[i]++;
               end
            end
            if (ab[i]) begin
               if (q.size() == 0 || q[0].id != i || !q[0].is_abort) unexp("abort", i);
               else begin
                  chk("abort_busy_cycles", scnt[i], q[0].scyc);
                  void'(q.pop_front());
               end
               scnt[i] = 0;
            end
            if (vo[i] && !p_valid[i]) begin
               if (q.size() == 0 || q[0].id != i || q[0].is_abort) unexp("valid", i);
               else begin
                  chk("result", res[i], q[0].res);
                  chk("start_cycles", scnt[i], q[0].scyc);
                  chk("valid_stall", {31'd0, stl[i]}, 32'd0);
                  chk("timeout_err", {31'd0, te[i]}, {31'd0, q[0].terr});
                  void'(q.pop_front());
               end
               scnt[i] = 0;
            end
            p_start[i] = st[i];
            p_valid[i] = vo[i];
         end
         if (end_req && !mon_done) begin
            chk("scoreboard_drained", q.size(), 32'd0);
            mon_done = 1;
         end
      end
   end

   task automatic push(input int id, input bit is_ab, input logic [31:0] r, input int scyc,
                       input bit s1, input bit s2, input bit md, input bit terr,
                       input logic [31:0] ea, input logic [31:0] eb);
      exp_t e;
      e.id = id; e.is_abort = is_ab; e.res = r; e.scyc = scyc;
      e.s1 = s1; e.s2 = s2; e.md = md; e.terr = terr; e.a = ea; e.b = eb;
      q.push_back(e);
   endtask

   task automatic issue(input int id, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      op[id] = o; a[id] = x; b[id] = y; req[id] = 1'b1;
   endtask

   task automatic finish_op(input int id);
      int n = 0;
      while (!vo[id] && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      adv[id] = 1'b1;
      @(posedge clk); #1;
      adv[id] = 1'b0;
      req[id] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic unit_op(input int id, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] r64, input int dly, input logic [31:0] er,
                          input bit s1, input bit s2, input bit md, input bit terr);
      push(id, 0, er, dly, s1, s2, md, terr, x, y);
      issue(id, o, x, y);
      @(posedge clk); #1;
      repeat (dly - 1) begin
         @(posedge clk); #1;
      end
      dn[id] = 1'b1;
      ur[id] = r64;
      @(posedge clk); #1;
      dn[id] = 1'b0;
      finish_op(id);
   endtask

   task automatic fast_op(input int id, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] er, input bit terr);
      push(id, 0, er, 0, 1, 1, 0, terr, x, y);
      issue(id, o, x, y);
      @(posedge clk); #1;
      finish_op(id);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; op[i] = 0; a[i] = 0; b[i] = 0; adv[i] = 0; fl[i] = 0; dn[i] = 0; ur[i] = 0;
         p_start[i] = 0; p_valid[i] = 0; scnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      unit_op(0, 3'd0, 32'd7, 32'd6, {32'h0, 32'd42}, 10, 32'd42, 1, 1, 0, 0);
      unit_op(0, 3'd1, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 3, 32'hFFFF_FFFF, 0, 0, 0, 0);
      unit_op(0, 3'd2, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 2, 32'hFFFF_FFFF, 0, 1, 0, 0);
      unit_op(0, 3'd3, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE}, 1, 32'h0000_0001, 1, 1, 0, 0);
      unit_op(0, 3'd5, 32'd100, 32'd7, {32'd14, 32'd2}, 4, 32'd14, 1, 1, 1, 0);
      unit_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 5, 32'hFFFF_FFFF, 0, 0, 1, 0);
      unit_op(0, 3'd7, 32'd9, 32'd4, {32'd2, 32'd1}, 2, 32'd1, 1, 1, 1, 0);
      unit_op(0, 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 2, 32'h0, 1, 1, 1, 0);

      fast_op(0, 3'd4, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
      fast_op(0, 3'd6, 32'd100, 32'd0, 32'd100, 0);
      fast_op(0, 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
      fast_op(0, 3'd7, 32'd5, 32'd0, 32'd5, 0);
      fast_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      fast_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

      // flush in the third BUSY cycle, then a stray done that must not produce a result
      push(0, 1, 32'h0, 3, 1, 1, 0, 0, 32'd3, 32'd5);
      issue(0, 3'd0, 32'd3, 32'd5);
      repeat (3) begin
         @(posedge clk); #1;
      end
      fl[0] = 1'b1;
      @(posedge clk); #1;
      fl[0] = 1'b0;
      req[0] = 1'b0;
      @(posedge clk); #1;
      dn[0] = 1'b1;
      ur[0] = {32'h0, 32'd15};
      @(posedge clk); #1;
      dn[0] = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end

      // watchdog on the short-timeout instance: abort on BUSY cycle 8, result 0, sticky error
      push(1, 1, 32'h0, 8, 1, 1, 0, 1, 32'd3, 32'd4);
      push(1, 0, 32'h0, 0, 1, 1, 0, 1, 32'd3, 32'd4);
      issue(1, 3'd0, 32'd3, 32'd4);
      finish_op(1);
      unit_op(1, 3'd3, 32'd10, 32'd20, {32'd5, 32'd0}, 8, 32'd5, 1, 1, 0, 1);
      fast_op(1, 3'd4, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);

      repeat (4) begin
         @(posedge clk); #1;
      end
      end_req = 1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
